// File: rtl/arm_fetch_unit_pkg.sv
// Shared ARM instruction-word layout and the fetch buffer entry type.
// Field positions are also used by the control/decode path.
package arm_fetch_unit_pkg;

   localparam int INSTR_W   = 32;

   localparam int COND_MSB  = 31;
   localparam int COND_LSB  = 28;
   localparam int OP_MSB    = 27;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 25;
   localparam int FUNCT_LSB = 20;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 12;

   localparam int ENTRY_W   = 2 * INSTR_W;

   typedef struct packed {
      logic [INSTR_W-1:0] word;
      logic [INSTR_W-1:0] pc;
   } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {instruction, pc}.
// Flush empties the buffer and wins over a same-cycle push.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               pushData,
   input  logic                       pop,
   input  logic                       flush,
   output logic [W-1:0]               headData,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic          doPush;
   logic          doPop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign doPop    = pop & ~empty;
   assign doPush   = push & ~flush;
   assign headData = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PW'(1);
         if (doPop)  rdPtr <= rdPtr + PW'(1);
         count <= count + CW'(doPush) - CW'(doPop);
      end
   end

   // Storage needs no reset; count gates what is visible.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction-fetch front end: credit-limited word requests to imem, prefetch
// buffering, field pre-split for decode, and redirect flush with response drop.
module arm_fetch_unit
   import arm_fetch_unit_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [3:0]  cond,
   output logic [1:0]  op,
   output logic [5:0]  funct,
   output logic [3:0]  rd
);

   localparam int          CW      = $clog2(DEPTH+1);
   localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

   logic [31:0]   pc;
   logic [31:0]   rspPc;
   logic [31:0]   target;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstandingNext;
   logic [CW-1:0] dropCnt;
   logic [CW-1:0] fifoCount;
   logic [CW:0]   inFlight;
   logic          reqFire;
   logic          rspHit;
   logic          rspDrop;
   logic          rspPush;
   logic          popFire;
   logic          fifoEmpty;
   logic          fifoFull;
   fetchEntry_t   pushEntry;
   fetchEntry_t   headEntry;
   logic [1:0]    unusedPcLow;

   assign target      = {redirect_pc[31:2], 2'b00};
   assign unusedPcLow = redirect_pc[1:0];

   // Credit covers both words in flight and words already buffered.
   assign inFlight       = {1'b0, outstanding} + {1'b0, fifoCount};
   assign imem_req_valid = rst_n & ~redirect & (inFlight < CREDITS);
   assign imem_addr      = pc;
   assign reqFire        = imem_req_valid & imem_req_ready;

   // Responses with nothing outstanding are stale (e.g. issued before a reset).
   assign rspHit  = imem_rsp_valid & (outstanding != '0);
   assign rspDrop = rspHit & (dropCnt != '0);
   assign rspPush = rspHit & (dropCnt == '0) & ~redirect;

   assign outstandingNext = outstanding + CW'(reqFire) - CW'(rspHit);

   assign popFire         = instr_valid & instr_ready;
   assign pushEntry.word  = imem_rsp_data;
   assign pushEntry.pc    = rspPc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         rspPc       <= RESET_PC;
         outstanding <= '0;
         dropCnt     <= '0;
      end else begin
         outstanding <= outstandingNext;
         if (redirect) begin
            // Everything still in flight after this cycle belongs to the old stream.
            pc      <= target;
            rspPc   <= target;
            dropCnt <= outstandingNext;
         end else begin
            if (reqFire) pc      <= pc + 32'd4;
            if (rspPush) rspPc   <= rspPc + 32'd4;
            if (rspDrop) dropCnt <= dropCnt - CW'(1);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) uFifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (rspPush),
      .pushData (pushEntry),
      .pop      (popFire),
      .flush    (redirect),
      .headData (headEntry),
      .count    (fifoCount),
      .empty    (fifoEmpty),
      .full     (fifoFull)
   );

   assign instr_valid = ~fifoEmpty;
   assign instr       = fifoEmpty ? '0 : headEntry.word;
   assign instr_pc    = fifoEmpty ? '0 : headEntry.pc;

   assign cond  = instr[COND_MSB:COND_LSB];
   assign op    = instr[OP_MSB:OP_LSB];
   assign funct = instr[FUNCT_MSB:FUNCT_LSB];
   assign rd    = instr[RD_MSB:RD_LSB];

   // Invariants the credit scheme relies on.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(rspPush && fifoFull && !popFire));
         assert (dropCnt <= outstanding);
      end
   end

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Directed + randomized bench for arm_fetch_unit with an in-order variable
// latency memory and a program-order stream scoreboard.
module tb_arm_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rd;

   arm_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .cond           (cond),
      .op             (op),
      .funct          (funct),
      .rd             (rd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } memReq_t;

   memReq_t     memQ[$];
   logic [31:0] accLog[$];
   int          checks = 0;
   int          errors = 0;
   int          cycN = 0;
   int          lastDue = 0;
   int          memLat = 1;
   int          popCnt = 0;
   int          accCnt = 0;
   int          firstAcc = -1;
   int          firstVal = -1;
   logic [31:0] expReq, expPop;
   logic [31:0] lastPopPc, lastPopInstr, lastReqAddr, firstInstr;
   logic [15:0] firstFields;
   logic        prevHold = 1'b0;
   logic [31:0] prevHeadPc = '0;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hE3A0_1005;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First half of a cycle: memory presents its in-order response, if due.
   task automatic cycPre();
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (memQ.size() > 0 && memQ[0].due <= cycN) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memWord(memQ[0].addr);
         void'(memQ.pop_front());
      end
      #1;
   endtask

   // Second half: observe handshakes, score them, advance the clock.
   task automatic cycPost();
      logic        fire, pop;
      logic [31:0] w;
      int          due;
      #1;
      fire = imem_req_valid & imem_req_ready;
      pop  = rst_n & instr_valid & instr_ready;
      if (!rst_n) chk("req_in_reset", imem_req_valid, 0);
      else if (redirect) chk("req_on_redirect", imem_req_valid, 0);
      if (prevHold) begin
         chk("head_hold_valid", instr_valid, 1);
         chk("head_hold_pc", instr_pc, prevHeadPc);
      end
      if (pop) begin
         w = memWord(expPop);
         chk("pop_pc", instr_pc, expPop);
         chk("pop_instr", instr, w);
         chk("pop_fields", {cond, op, funct, rd},
             {4'(w >> 28), 2'(w >> 26), 6'(w >> 20), 4'(w >> 12)});
         if (popCnt == 0) begin
            firstInstr  = instr;
            firstFields = {cond, op, funct, rd};
         end
         lastPopPc    = instr_pc;
         lastPopInstr = instr;
         popCnt++;
         expPop += 32'd4;
      end
      if (fire) begin
         chk("req_addr", imem_addr, expReq);
         lastReqAddr = imem_addr;
         accLog.push_back(imem_addr);
         accCnt++;
         if (firstAcc < 0) firstAcc = cycN;
         due = cycN + memLat;
         if (due <= lastDue) due = lastDue + 1;
         lastDue = due;
         memQ.push_back('{addr: imem_addr, due: due});
         expReq += 32'd4;
         chk("credit", memQ.size() <= DEPTH, 1);
      end
      if (firstVal < 0 && rst_n && instr_valid) firstVal = cycN;
      if (redirect && rst_n) begin
         expPop = {redirect_pc[31:2], 2'b00};
         expReq = {redirect_pc[31:2], 2'b00};
      end
      if (!rst_n) begin
         expPop = RESET_PC;
         expReq = RESET_PC;
      end
      prevHold   = rst_n & instr_valid & ~instr_ready & ~redirect;
      prevHeadPc = instr_pc;
      @(posedge clk);
      #1;
      cycN++;
   endtask

   task automatic cyc();
      cycPre();
      cycPost();
   endtask

   task automatic releaseReset();
      rst_n    = 1'b1;
      firstAcc = -1;
      firstVal = -1;
      accCnt   = 0;
      popCnt   = 0;
      accLog.delete();
   endtask

   task automatic drain();
      int n = 0;
      imem_req_ready = 1'b0;
      while (memQ.size() > 0 && n < 40) begin
         cyc();
         n++;
      end
      chk("drain", memQ.size(), 0);
      repeat (3) cyc();
      imem_req_ready = 1'b1;
   endtask

   task automatic waitPop(input string tag, input logic [31:0] pcExp);
      int m = popCnt;
      int n = 0;
      while (popCnt == m && n < 40) begin
         cyc();
         n++;
      end
      chk({tag, "_seen"}, popCnt != m, 1);
      chk({tag, "_pc"}, lastPopPc, pcExp);
      chk({tag, "_instr"}, lastPopInstr, memWord(pcExp));
   endtask

   initial begin
      int   n, m;
      logic hit;
      rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1; memLat = 1;
      expReq = RESET_PC; expPop = RESET_PC;

      // Reset state, then streaming at latency 1.
      cyc(); cyc();
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_fields", {cond, op, funct, rd}, 0);
      chk("rst_req", imem_req_valid, 0);
      releaseReset();
      repeat (12) cyc();
      chk("first_latency", firstVal - firstAcc, 2);
      chk("stream_len", accLog.size() >= 3, 1);
      if (accLog.size() >= 3) begin
         chk("stream_a0", accLog[0], 32'h0);
         chk("stream_a1", accLog[1], 32'h4);
         chk("stream_a2", accLog[2], 32'h8);
      end
      chk("stream_pops", popCnt >= 3, 1);
      chk("first_instr", firstInstr, 32'hE3A0_1005);
      chk("first_fields", firstFields, {4'hE, 2'h0, 6'h3A, 4'h1});

      // Decode stalled: credit caps issue at DEPTH.
      drain();
      rst_n = 1'b0; cyc(); releaseReset();
      instr_ready = 1'b0;
      repeat (20) cyc();
      chk("hold_accepts", accCnt, DEPTH);
      chk("hold_req_valid", imem_req_valid, 0);
      chk("hold_head_valid", instr_valid, 1);
      chk("hold_head_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      repeat (10) cyc();
      chk("resume_accepts", accCnt > DEPTH, 1);

      // Redirect with two late responses in flight.
      drain();
      rst_n = 1'b0; cyc(); releaseReset();
      memLat = 3;
      n = 0;
      while (memQ.size() < 2 && n < 10) begin cyc(); n++; end
      chk("two_outstanding", memQ.size(), 2);
      redirect = 1'b1; redirect_pc = 32'h100; cyc(); redirect = 1'b0;
      waitPop("redir_drop", 32'h100);

      // Redirect coinciding with a head pop and a response arrival.
      memLat = 1; hit = 1'b0; n = 0; m = 0;
      while (!hit && n < 40) begin
         cycPre();
         if (instr_valid && imem_rsp_valid) begin
            redirect = 1'b1; redirect_pc = 32'h3000; hit = 1'b1; m = popCnt;
         end
         cycPost();
         redirect = 1'b0;
         n++;
      end
      chk("redir_pop_hit", hit, 1);
      chk("redir_pop_once", popCnt, m + 1);
      waitPop("redir_pop", 32'h3000);

      // Unaligned target.
      redirect = 1'b1; redirect_pc = 32'h203; cyc(); redirect = 1'b0;
      m = accCnt; n = 0;
      while (accCnt == m && n < 20) begin cyc(); n++; end
      chk("align_addr", lastReqAddr, 32'h200);
      waitPop("align", 32'h200);

      // Back-to-back redirects: last one wins.
      redirect = 1'b1; redirect_pc = 32'h400; cyc();
      redirect_pc = 32'h800; cyc(); redirect = 1'b0;
      waitPop("b2b", 32'h800);

      // Address wrap at the top of memory.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; cyc(); redirect = 1'b0;
      m = accLog.size(); n = 0;
      while (accLog.size() < m + 2 && n < 20) begin cyc(); n++; end
      chk("wrap_reqs", accLog.size() >= m + 2, 1);
      if (accLog.size() >= m + 2) begin
         chk("wrap_a0", accLog[m], 32'hFFFF_FFFC);
         chk("wrap_a1", accLog[m+1], 32'h0);
      end

      // Reset with requests outstanding; stale words arrive after release.
      drain();
      memLat = 3;
      n = 0;
      while (memQ.size() < 2 && n < 20) begin cyc(); n++; end
      chk("rst_two_outstanding", memQ.size(), 2);
      rst_n = 1'b0; cyc(); releaseReset();
      imem_req_ready = 1'b0;
      n = 0;
      while (memQ.size() > 0 && n < 20) begin cyc(); n++; end
      chk("stale_gone", memQ.size(), 0);
      chk("stale_no_valid", instr_valid, 0);
      imem_req_ready = 1'b1;
      waitPop("rst_restart0", RESET_PC);
      waitPop("rst_restart1", RESET_PC + 32'd4);

      // Randomized traffic; the scoreboard checks every handshake.
      m = popCnt;
      repeat (1500) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         instr_ready    = ($urandom_range(0, 3) != 0);
         memLat         = $urandom_range(1, 4);
         cycPre();
         if ($urandom_range(0, 19) == 0) begin
            redirect    = 1'b1;
            redirect_pc = $urandom;
         end
         cycPost();
         redirect = 1'b0;
      end
      chk("rand_progress", (popCnt - m) > 50, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
